// File: rtl/disp_scheduler_if.sv
// Handshake and display bus between the requesters, disp_scheduler and the digit multiplexer.
interface disp_scheduler_if;
    logic [15:0] Value;
    logic        MsgReq;
    logic [31:0] MsgSegs;
    logic        MsgAck;
    logic        Owner;
    logic        ScanTick;
    logic [7:0]  seg0;
    logic [7:0]  seg1;
    logic [7:0]  seg2;
    logic [7:0]  seg3;

    modport master (
        output Value, MsgReq, MsgSegs,
        input  MsgAck, Owner, ScanTick, seg0, seg1, seg2, seg3
    );

    modport slave (
        input  Value, MsgReq, MsgSegs,
        output MsgAck, Owner, ScanTick, seg0, seg1, seg2, seg3
    );
endinterface

// File: rtl/disp_scheduler.sv
// Shares the 4-digit seven-segment display between the live hex value and timed raw messages.
// Optional: DISP_LEADING_ZERO_BLANK_EN blanks leading zero digits of the value (seg3 never blanked).
module disp_scheduler #(
    parameter int unsigned DIV        = 16,
    parameter int unsigned HOLD_TICKS = 1024
) (
    input logic             Clk,
    input logic             RstN,
    disp_scheduler_if.slave bus
);
    localparam int unsigned DW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_PRE  = DW'(DIV - 2);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    typedef enum logic {SHOW_VAL, SHOW_MSG} state_t;

    state_t          state;
    logic [DW-1:0]   div_cnt;
    logic [HW-1:0]   hold_cnt;
    logic            scan_tick;
    logic            msg_ack;
    logic            owner;
    logic [3:0][7:0] segs;
    logic [3:0][7:0] val_segs;
    logic [3:0][7:0] msg_segs;

    function automatic logic [7:0] hex7(input logic [3:0] nib);
        hex7 = '1;
        case (nib)
            4'h0: hex7 = 8'hC0;
            4'h1: hex7 = 8'hF9;
            4'h2: hex7 = 8'hA4;
            4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;
            4'h5: hex7 = 8'h92;
            4'h6: hex7 = 8'h82;
            4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;
            4'h9: hex7 = 8'h90;
            4'hA: hex7 = 8'h88;
            4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;
            4'hD: hex7 = 8'hA1;
            4'hE: hex7 = 8'h86;
            4'hF: hex7 = 8'h8E;
        endcase
    endfunction

    // segs[0] is the leftmost digit and carries the most significant nibble.
    always_comb begin
        logic [3:0] nib;
`ifdef DISP_LEADING_ZERO_BLANK_EN
        logic lead;
        lead = 1'b1;
`endif
        val_segs = '1;
        for (int unsigned i = 0; i < 4; i++) begin
            nib = 4'(bus.Value >> (4 * (3 - i)));
            val_segs[i] = hex7(nib);
`ifdef DISP_LEADING_ZERO_BLANK_EN
            if (i < 3 && lead && nib == 4'h0) val_segs[i] = '1;
            if (nib != 4'h0) lead = 1'b0;
`endif
        end
    end

    assign msg_segs = {bus.MsgSegs[7:0], bus.MsgSegs[15:8], bus.MsgSegs[23:16], bus.MsgSegs[31:24]};

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state     <= SHOW_VAL;
            div_cnt   <= '0;
            hold_cnt  <= '0;
            scan_tick <= 1'b0;
            msg_ack   <= 1'b0;
            owner     <= 1'b0;
            segs      <= '1;
        end else begin
            div_cnt   <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            // Registered tick lines up with the cycle in which div_cnt holds DIV-1.
            scan_tick <= (div_cnt == DIV_PRE);
            msg_ack   <= 1'b0;
            case (state)
                SHOW_VAL: begin
                    if (bus.MsgReq) begin
                        state    <= SHOW_MSG;
                        owner    <= 1'b1;
                        msg_ack  <= 1'b1;
                        hold_cnt <= HOLD_INIT;
                        segs     <= msg_segs;
                    end else begin
                        segs <= val_segs;
                    end
                end
                SHOW_MSG: begin
                    if (scan_tick) begin
                        if (hold_cnt == HOLD_ONE) begin
                            state <= SHOW_VAL;
                            owner <= 1'b0;
                            segs  <= val_segs;
                        end else begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state <= SHOW_VAL;
                    owner <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ScanTick = scan_tick;
    assign bus.MsgAck   = msg_ack;
    assign bus.Owner    = owner;
    assign bus.seg0     = segs[0];
    assign bus.seg1     = segs[1];
    assign bus.seg2     = segs[2];
    assign bus.seg3     = segs[3];
endmodule

// File: doc/disp_scheduler.md
# disp_scheduler

- Sequences and shares the four-digit seven-segment scan display between two requesters:
  - the live counter value, shown as four hex digits;
  - a transient raw-pattern message, shown for a fixed number of scan ticks.
- Also generates the scan-rate enable that advances the digit multiplexer.
- Sits between the counter/control logic and the display multiplexer; drives its four digit-pattern inputs.

## Interface
Parameters:
- DIV, 16: Clk cycles per scan tick (≥2).
- HOLD_TICKS, 1024: scan ticks a message stays displayed (≥1).

Ports:
- Clk  in  1  system clock; single clock domain, all logic on rising edge.
- RstN  in  1  asynchronous, active-low reset.
- Value  in  16  counter value; Value[15:12] shows on seg0 (leftmost) … Value[3:0] on seg3 (rightmost).
- MsgReq  in  1  message request; level, held by requester until MsgAck.
- MsgSegs  in  32  raw patterns; [31:24]→seg0 … [7:0]→seg3.
- MsgAck  out  1  one-cycle acceptance pulse.
- Owner  out  1  0 = value shown, 1 = message shown.
- ScanTick  out  1  one-cycle enable per DIV cycles, for the digit multiplexer.
- seg0..seg3  out  8 each  digit patterns, active-low, bit7 = dp, bits6:0 = g,f,e,d,c,b,a.

## Operation
- Divider:
  - counter 0..DIV-1, wraps to 0;
  - ScanTick = 1 in the cycle the counter equals DIV-1.
- FSM states: SHOW_VAL, SHOW_MSG.
- SHOW_VAL:
  - segN = hex encoding of the corresponding nibble, dp off;
  - encodings: 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E.
- Transition SHOW_VAL → SHOW_MSG, at the edge where MsgReq = 1 in SHOW_VAL:
  - MsgSegs latched;
  - hold counter loaded with HOLD_TICKS;
  - MsgAck = 1 for the following cycle only.
- SHOW_MSG:
  - segN = latched pattern;
  - hold counter decrements on each ScanTick;
  - a ScanTick with hold counter = 1 returns the FSM to SHOW_VAL.
- MsgReq during SHOW_MSG: ignored, not acked, not latched.
  - If still asserted after return, it is accepted on the first SHOW_VAL cycle, giving back-to-back messages.
- A requester must drop MsgReq in the cycle after MsgAck. If MsgReq is still high two cycles after MsgAck, it is a new request, deferred until the hold expires.
- Owner = 1 exactly while in SHOW_MSG.

## Timing
- Reset values:
  - seg0..seg3 = 8'hFF (all off);
  - MsgAck = 0, Owner = 0, ScanTick = 0;
  - divider = 0, state SHOW_VAL.
- All outputs are registered.
- Value change → seg update: 1 cycle.
- MsgReq sampled high → MsgAck, Owner and segs show the message: all 1 cycle later, same cycle.
- Message display duration: exactly HOLD_TICKS ScanTicks. The first decrement is the first ScanTick strictly after acceptance.
- ScanTick in the acceptance cycle does not count toward the hold.
- The divider runs free; it is not reset by message events.
- Reset asserted mid-message: immediate return to reset values; the latched message is discarded; no MsgAck is issued.
- First ScanTick after reset release: cycle DIV-1.

## Configuration
- DISP_LEADING_ZERO_BLANK_EN:
  - Defined: in SHOW_VAL, leading zero nibbles from seg0 rightward show FF. seg3 is never blanked. A zero after the first non-zero digit is shown.
  - Undefined: all four nibbles always shown.
- Message patterns are never affected by the macro.

## Test plan
- Reset, Value=16'h12AF, DIV=4:
  - segs = F9, A4, 88, 8E after one cycle;
  - ScanTick high at cycles 3, 7, 11 after release.
- With DISP_LEADING_ZERO_BLANK_EN:
  - Value=16'h0042 → FF, FF, 99, A4;
  - Value=16'h0000 → FF, FF, FF, C0;
  - Value=16'h0400 → FF, 99, C0, C0.
- MsgReq with MsgSegs=32'h01020304, HOLD_TICKS=3, DIV=4:
  - MsgAck single pulse; Owner = 1;
  - segs 01, 02, 03, 04 for exactly 3 ScanTicks;
  - then value restored the cycle after the third tick.
- Second MsgReq asserted mid-message:
  - no ack until Owner falls;
  - then accepted the next cycle (Owner back to 1 after one SHOW_VAL cycle) with the new pattern.
- RstN pulsed low during SHOW_MSG → segs FF, Owner 0 asynchronously; after release, value shown and no MsgAck.
- Value changes while in SHOW_MSG → message segs unchanged; new value shown on return.
